cla_seq_ctrl: RTL and testbench

- Sequencing controller that performs a WIDTH-bit add or subtract by time-multiplexing one registered 4-bit carry-lookahead adder slice (ports clk/load/a/b/Cin/Q[4:0]).
- Issues one nibble per pass, least-significant first, and chains the slice carry-out into the next nibble's Cin.
- Latches operands on start and returns sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between the control logic and the shared cla slice.

---
 rtl/cla_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_cla_seq_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// Sequencing controller: performs a WIDTH-bit add/subtract by issuing one
// nibble per pass to a shared registered 4-bit carry-lookahead slice,
// least-significant nibble first, chaining the slice carry between passes.
module cla_seq_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 sub,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 cla_load,
   output logic [3:0]           cla_a,
   output logic [3:0]           cla_b,
   output logic                 cla_cin,
   input  logic [4:0]           cla_q
);

   localparam int unsigned WIDTH = 4 * NIBBLES;
   localparam int unsigned IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [IW+1:0]    bit_base;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic             last_nib;

   // Bit offset of the current nibble and the operand nibbles it selects.
   assign bit_base = {idx, 2'b00};
   assign a_nib    = a_r[bit_base +: 4];
   assign b_nib    = b_r[bit_base +: 4];
   assign last_nib = (idx == LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic and slice drive decoded from state and nibble index.
   always_comb begin
      state_nx = state;
      cla_load = 1'b0;
      cla_a    = 4'h0;
      cla_b    = 4'h0;
      cla_cin  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            cla_load = 1'b1;
            cla_a    = a_nib;
            cla_b    = b_nib;
            cla_cin  = carry_r;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            state_nx = last_nib ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand latch, per-nibble result capture and registered status outputs.
   // cout/ovf are loaded on the edge into DONE from the final slice result so
   // they are valid alongside the done pulse; ovf uses the final nibble MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         sum     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r     <= op_a;
                  b_r     <= sub ? ~op_b : op_b;
                  carry_r <= sub | cin;
                  sum     <= '0;
                  idx     <= '0;
                  busy    <= 1'b1;
               end
            end
            S_WAIT: begin
               sum[bit_base +: 4] <= cla_q[3:0];
               carry_r            <= cla_q[4];
               if (last_nib) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  cout <= cla_q[4];
                  ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                          (cla_q[3] != a_r[WIDTH-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               done <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed self-checking bench for cla_seq_ctrl with a behavioural
// registered 4-bit CLA slice model.
module tb_cla_seq_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         cla_load;
   logic [3:0]   cla_a;
   logic [3:0]   cla_b;
   logic         cla_cin;
   logic [4:0]   cla_q;

   int n_tests;
   int n_fail;

   logic [3:0] cap_b   [N];
   logic       cap_cin [N];

   cla_seq_ctrl #(.NIBBLES(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .cla_load (cla_load),
      .cla_a    (cla_a),
      .cla_b    (cla_b),
      .cla_cin  (cla_cin),
      .cla_q    (cla_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered 4-bit adder slice: Q valid the cycle after load.
   initial cla_q = 5'h00;
   always @(posedge clk) begin
      if (cla_load) cla_q <= {1'b0, cla_a} + {1'b0, cla_b} + 5'(cla_cin);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one operation starting at the next negedge (cycle 0). Checks the
   // busy/load/done timeline each cycle and the result in the done cycle.
   // A nonzero rej_cyc injects a start with different operands at that cycle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf,
                         input logic hold_cout, input logic hold_ovf, input int rej_cyc);
      int nib;
      logic [2:0] exp_ctl;
      nib = 0;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
      @(negedge clk);
      start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      for (int cyc = 1; cyc <= 2 * N + 1; cyc++) begin
         if (cyc > 1) @(negedge clk);
         exp_ctl = {cyc <= 2 * N, (cyc % 2 == 1) && (cyc <= 2 * N - 1), cyc == 2 * N + 1};
         check({tag, " busy/load/done"}, 32'({busy, cla_load, done}), 32'(exp_ctl));
         if (cyc == 1) begin
            check({tag, " cout held"}, 32'(cout), 32'(hold_cout));
            check({tag, " ovf held"}, 32'(ovf), 32'(hold_ovf));
         end
         if (cla_load && nib < N) begin
            cap_b[nib]   = cla_b;
            cap_cin[nib] = cla_cin;
            nib++;
         end
         if (cyc == rej_cyc) begin
            start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0F0F; sub = 1'b1;
         end else begin
            start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
         end
      end
      check({tag, " sum"}, 32'(sum), 32'(exp_sum));
      check({tag, " cout"}, 32'(cout), 32'(exp_cout));
      check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
   endtask

   int done_cnt;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset outputs", 32'({busy, done, cout, ovf, cla_load, cla_cin}), 32'h0);
      check("reset sum", 32'(sum), 32'h0);
      check("reset slice a/b", 32'({cla_a, cla_b}), 32'h0);
      rst_n = 1'b1;

      // Plain add with a rejected start at cycle 3; follow-on op accepted at cycle 10.
      run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      check("add nib0 b", 32'(cap_b[0]), 32'h1);

      // Overflow op starts the cycle after done.
      run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Full ripple; cout/ovf from previous op must hold while busy.
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      check("ripple cin nibs", 32'({cap_cin[3], cap_cin[2], cap_cin[1], cap_cin[0]}), 32'hE);

      // Subtract with borrow; cin ignored.
      run_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("sub nib0 b", 32'(cap_b[0]), 32'h8);
      check("sub nib0 cin", 32'(cap_cin[0]), 32'h1);

      // Add-mode carry-in honoured.
      run_op("addcin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Result held after done.
      repeat (3) @(negedge clk);
      check("sum held", 32'(sum), 32'h0010);

      // Reset abort at cycle 4 of an operation.
      start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-abort busy/sum", 32'({busy, sum}), 32'({1'b1, 16'h0005}));
      rst_n = 1'b0;
      #1;
      check("abort outputs", 32'({busy, cla_load, done}), 32'h0);
      check("abort sum", 32'(sum), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      check("no done after abort", 32'(done_cnt), 32'h0);

      run_op("post-abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
